prio_arb_nto1: RTL

//   Registered N-requester arbiter. It generalises the 4-to-2 priority encoder
//   to N inputs and adds a selectable mode: fixed priority or round-robin.
//   It adds grant holding, with a hold-limit preemption counter.
//   It sits in front of shared resources (bus, memory port) and returns a one-hot

---
 rtl/prio_arb_nto1.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prio_arb_nto1.sv
// Registered N-requester arbiter with fixed-priority or round-robin
// selection and a hold-limit preemption counter.
module prio_arb_nto1 #(
    parameter int N        = 4,
    parameter int RR       = 0,
    parameter int MAX_HOLD = 8,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HMAX =
        (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   others;
    logic [W-1:0]   win_all;
    logic [W-1:0]   win_pre;

    // Fixed: last set bit wins. RR: first set bit at or after the pointer.
    function automatic logic [W-1:0] pick(
        input logic [N-1:0] c,
        input logic [W-1:0] p
    );
        logic [W-1:0] w;
        logic         found;
        int           j;
        w     = '0;
        found = 1'b0;
        if (RR == 0) begin
            for (int i = 0; i < N; i++) begin
                if (c[i]) begin
                    w = W'(i);
                end
            end
        end else begin
            for (int off = 0; off < N; off++) begin
                j = int'(p) + off;
                if (j >= N) begin
                    j = j - N;
                end
                if (c[j] && !found) begin
                    w     = W'(j);
                    found = 1'b1;
                end
            end
        end
        return w;
    endfunction

    assign others  = req & ~gnt_q;
    assign win_all = pick(req, ptr_q);
    assign win_pre = pick(others, ptr_q);

    always_comb begin
        logic         do_grant;
        logic [W-1:0] widx;
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        do_grant = 1'b0;
        widx     = win_all;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    if (|req) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                    end
                end else if (MAX_HOLD != 0 && hold_q == HMAX
                             && |others) begin
                    do_grant = 1'b1;
                    widx     = win_pre;
                end else if (MAX_HOLD != 0 && hold_q != HMAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_grant) begin
            state_d = GRANT;
            gnt_d   = N'(1) << widx;
            idx_d   = widx;
            hold_d  = '0;
            ptr_d   = (widx == W'(N - 1)) ? '0 : widx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;

endmodule
